// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, combinational imem address, and a small
// {pc, instr} FIFO toward decode. Optional performance counters under FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
    parameter int unsigned              QUEUE_DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_instr,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    input  logic                     dec_ready,
    output logic                     dec_valid,
    output logic [DATA_WIDTH-1:0]    dec_instr,
    output logic [ADDRESS_WIDTH-1:0] dec_pc,
    output logic [ADDRESS_WIDTH-1:0] dec_pc_plus4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]              perf_fetch_cnt,
    output logic [31:0]              perf_stall_cnt,
    output logic [31:0]              perf_flush_cnt
`endif
);

    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

    localparam logic [CNT_W-1:0]         FULL_CNT  = CNT_W'(QUEUE_DEPTH);
    localparam logic [DATA_WIDTH-1:0]    NOP_INSTR = DATA_WIDTH'(32'h0000_0013);
    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP   = ADDRESS_WIDTH'(4);
    localparam logic [ADDRESS_WIDTH-1:0] PC_BOOT   = {RESET_PC[ADDRESS_WIDTH-1:2], 2'b00};

    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;

    logic [ADDRESS_WIDTH-1:0] q_pc_q    [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0]    q_instr_q [QUEUE_DEPTH];

    logic enq;
    logic deq;
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign imem_addr = pc_q;
    assign dec_valid = (count_q != '0);
    assign deq       = dec_valid & dec_ready;
    // A full queue can still accept a fetch when the head leaves on the same edge.
    assign enq       = !redirect_valid & ((count_q < FULL_CNT) | deq);

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            pc_d     = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                pc_d     = pc_q + PC_STEP;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= PC_BOOT;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset; count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            q_pc_q[wr_ptr_q]    <= pc_q;
            q_instr_q[wr_ptr_q] <= imem_instr;
        end
    end

    always_comb begin
        dec_instr = NOP_INSTR;
        dec_pc    = '0;
        if (dec_valid) begin
            dec_instr = q_instr_q[rd_ptr_q];
            dec_pc    = q_pc_q[rd_ptr_q];
        end
    end

    assign dec_pc_plus4 = dec_pc + PC_STEP;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (enq)                     perf_fetch_q <= sat_inc(perf_fetch_q);
            if (dec_valid && !dec_ready) perf_stall_q <= sat_inc(perf_stall_q);
            if (redirect_valid)          perf_flush_q <= sat_inc(perf_flush_q);
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus, negedge monitor on decode handshakes.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr, imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic        dec_valid;
    logic [31:0] dec_instr, dec_pc, dec_pc_plus4;

    logic [31:0] imem_addr2, imem_instr2;
    logic        redirect_valid2 = 1'b0;
    logic [31:0] redirect_pc2 = 32'h0;
    logic        dec_ready2 = 1'b1;
    logic        dec_valid2;
    logic [31:0] dec_instr2, dec_pc2, dec_pc_plus4_2;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
    logic [31:0] perf_fetch_cnt2, perf_stall_cnt2, perf_flush_cnt2;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Memory word k holds 32'h1000_0000 + k.
    assign imem_instr  = 32'h1000_0000 + {2'b00, imem_addr[31:2]};
    assign imem_instr2 = 32'h1000_0000 + {2'b00, imem_addr2[31:2]};

    fetch_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0), .QUEUE_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_ready(dec_ready), .dec_valid(dec_valid),
        .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_pc_plus4(dec_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    fetch_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .QUEUE_DEPTH(2)) dut2 (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr2), .imem_instr(imem_instr2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .dec_ready(dec_ready2), .dec_valid(dec_valid2),
        .dec_instr(dec_instr2), .dec_pc(dec_pc2), .dec_pc_plus4(dec_pc_plus4_2)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt2), .perf_stall_cnt(perf_stall_cnt2),
        .perf_flush_cnt(perf_flush_cnt2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = 32'h1000_0000 + {2'b00, pc[31:2]};
        sb.push_back(e);
    endtask

    // Monitor: every head accepted by decode must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && !redirect_valid && dec_valid && dec_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: unexpected head pc %08h instr %08h", dec_pc, dec_instr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_pc", dec_pc, e.pc);
                chk("sb_instr", dec_instr, e.instr);
                chk("sb_pc_plus4", dec_pc_plus4, e.pc + 32'd4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held_pc, held_instr;
        rst = 1'b1; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        step(); step();
        chk("rst_valid", {31'b0, dec_valid}, 32'd0);
        chk("rst_instr", dec_instr, 32'h0000_0013);
        chk("rst_pc", dec_pc, 32'h0);
        chk("rst_pc_plus4", dec_pc_plus4, 32'h4);
        chk("rst_imem_addr", imem_addr, 32'h0);

        // Streaming from reset with decode always ready; dut2 exercises PC wrap.
        for (int k = 0; k < 6; k++) push_exp(32'(k * 4));
        rst = 1'b0; dec_ready = 1'b1;
        step();
        chk("first_valid", {31'b0, dec_valid}, 32'd1);
        chk("wrap_pc0", dec_pc2, 32'hFFFF_FFFC);
        chk("wrap_plus4_0", dec_pc_plus4_2, 32'h0);
        chk("wrap_instr0", dec_instr2, 32'h4FFF_FFFF);
        step();
        chk("wrap_pc1", dec_pc2, 32'h0);
        chk("wrap_plus4_1", dec_pc_plus4_2, 32'h4);
        chk("wrap_instr1", dec_instr2, 32'h1000_0000);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stream_valid", {31'b0, dec_valid}, 32'd1);
        end
        dec_ready = 1'b0;
        chk("stream_drained", 32'(sb.size()), 32'd0);

        // Back-pressure: queue fills, PC holds at 8, head stays put.
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step(); step();
        held_pc = dec_pc; held_instr = dec_instr;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_head_pc", dec_pc, held_pc);
            chk("stall_head_instr", dec_instr, held_instr);
        end
        chk("full_imem_addr", imem_addr, 32'h8);
        chk("full_head_pc", dec_pc, 32'h0);
        chk("full_head_instr", dec_instr, 32'h1000_0000);

        // Full queue, one ready cycle: simultaneous dequeue and enqueue.
        push_exp(32'h0);
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        chk("fullrw_imem_addr", imem_addr, 32'hC);
        chk("fullrw_head_pc", dec_pc, 32'h4);
        chk("fullrw_head_instr", dec_instr, 32'h1000_0001);
        step();
        chk("fullrw_still_full", imem_addr, 32'hC);

        // Redirect on a full queue, decode ready: flush without dequeue.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; dec_ready = 1'b1;
        step();
        redirect_valid = 1'b0; dec_ready = 1'b0;
        chk("redir_valid", {31'b0, dec_valid}, 32'd0);
        chk("redir_imem_addr", imem_addr, 32'h100);
        chk("redir_pc", dec_pc, 32'h0);
        chk("redir_pc_plus4", dec_pc_plus4, 32'h4);
        chk("redir_instr", dec_instr, 32'h0000_0013);
        step();
        chk("redir_tgt_valid", {31'b0, dec_valid}, 32'd1);
        chk("redir_tgt_pc", dec_pc, 32'h100);
        chk("redir_tgt_plus4", dec_pc_plus4, 32'h104);
        chk("redir_tgt_instr", dec_instr, 32'h1000_0040);

        // Stream from the redirect target.
        for (int k = 0; k < 8; k++) push_exp(32'h100 + 32'(k * 4));
        dec_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("redir_stream_valid", {31'b0, dec_valid}, 32'd1);
        end
        dec_ready = 1'b0;
        chk("redir_stream_drained", 32'(sb.size()), 32'd0);

        // Reset wins over a simultaneous redirect.
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        rst = 1'b0; redirect_valid = 1'b0;
        chk("rstovr_imem_addr", imem_addr, 32'h0);
        chk("rstovr_valid", {31'b0, dec_valid}, 32'd0);
        step();
        chk("rstovr_head_pc", dec_pc, 32'h0);
        chk("rstovr_head_valid", {31'b0, dec_valid}, 32'd1);

`ifdef FETCH_PERF_CNT_EN
        rst = 1'b1;
        step();
        rst = 1'b0; dec_ready = 1'b0;
        for (int k = 0; k < 4; k++) step();
        push_exp(32'h0); push_exp(32'h4);
        dec_ready = 1'b1;
        step(); step();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0; dec_ready = 1'b0;
        chk("perf_fetch", perf_fetch_cnt, 32'd4);
        chk("perf_stall", perf_stall_cnt, 32'd3);
        chk("perf_flush", perf_flush_cnt, 32'd1);
`endif

        step();
        chk("final_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
